io_port_decoder: RTL
====================

Name: io_port_decoder

Overview:
- Parametrised, clocked successor to the single-window DMA chip-select decoder.
- Decodes host I/O cycles (Address, nIOR, nIOW) against NUM_DEV base-address windows and drives one registered active-low chip select per device.
- Also provides one-cycle read/write strobes, a decode-miss flag and a conflict flag.
- Ignores addresses while AEN is high, i.e. while the DMA controller owns the bus.
- Sits between the SystemBus and the DMA controller plus neighbouring peripherals.

Parameters:
- ADDR_W, 16: I/O address width.
- NUM_DEV, 2: number of decoded devices, 1..8.
- WINDOW_BITS, 4: low address bits ignored in the compare, giving a uniform window of 2^WINDOW_BITS ports per device.
- BASE_ADDRS, {16'h0080,16'hFFF0}: packed NUM_DEV*ADDR_W vector; slice k is the base of device k. Bits below WINDOW_BITS are ignored.
- SYNC_STAGES, 2: synchroniser flops on nIOR/nIOW, 1..3.
- RECOVERY_CYCLES, 2: idle clocks enforced after each access, 0..15.

Ports:
- CLK, input, 1: system clock, rising edge.
- nRESET, input, 1: asynchronous active-low reset.
- Address, input, ADDR_W: I/O address.
- nIOR, input, 1: active-low I/O read strobe, asynchronous to CLK.
- nIOW, input, 1: active-low I/O write strobe, asynchronous to CLK.
- AEN, input, 1: address enable; 1 means DMA owns the bus and decode is suppressed.
- nCS, output, NUM_DEV: active-low chip selects, registered, at most one low.
- DevIdx, output, clog2(NUM_DEV) (min 1): index of the selected device, valid while any nCS is low.
- RdStb, output, 1: one-cycle pulse at the start of a decoded read.
- WrStb, output, 1: one-cycle pulse at the start of a decoded write.
- DecodeMiss, output, 1: one-cycle pulse when a strobe starts with no window hit.
- Conflict, output, 1: one-cycle pulse when nIOR and nIOW are both seen low.
- Busy, output, 1: high whenever the FSM is not in IDLE.

Behaviour:
- Reset (asynchronous, nRESET=0):
  - nCS all 1; DevIdx, RdStb, WrStb, DecodeMiss, Conflict, Busy all 0.
  - FSM goes to IDLE; synchroniser flops set to 1 (strobes inactive).
  - Reset mid-access drops nCS to all 1 immediately.
- Synchronisers:
  - rd_s and wr_s are the outputs of the SYNC_STAGES flop chains, active high.
  - All FSM decisions use rd_s and wr_s only.
- Hit test: hit[k] = (Address[ADDR_W-1:WINDOW_BITS] == BASE_ADDRS slice k [ADDR_W-1:WINDOW_BITS]).
  - Overlapping windows resolve to the lowest index.
  - Address is sampled raw at the decode edge; the bus guarantees it is stable while the strobe is low.
- FSM states: IDLE, ACCESS, HOLD_MISS, RECOVER. All outputs are registered and update on the transition edge.
- IDLE:
  - rd_s & wr_s: pulse Conflict, go to HOLD_MISS, no nCS.
  - Exactly one strobe with AEN=1: go to HOLD_MISS, no pulse.
  - Exactly one strobe, AEN=0, some hit: go to ACCESS, drive nCS[k]=0, DevIdx=k, and pulse RdStb or WrStb to match the strobe.
  - Exactly one strobe, AEN=0, no hit: pulse DecodeMiss, go to HOLD_MISS.
- ACCESS:
  - Hold nCS[k] low while the originating strobe stays asserted. Address changes are ignored, since the device is latched.
  - Other strobe also asserting: pulse Conflict; nCS stays low until the original strobe releases.
  - Originating strobe deasserts: nCS goes all 1 on that edge. Go to RECOVER, or to IDLE if RECOVERY_CYCLES==0.
- HOLD_MISS: wait until rd_s=0 and wr_s=0, then go to RECOVER (or IDLE if RECOVERY_CYCLES==0).
- RECOVER:
  - The counter loads RECOVERY_CYCLES-1 on entry and decrements each clock.
  - At 0 go to IDLE; strobes seen during RECOVER are ignored until IDLE.
  - A strobe still held low on return to IDLE starts a new decode, which is the back-to-back case.
- Latency (SYNC_STAGES=2): a pin assertion set up before edge E1 gives nCS low and the strobe pulse after edge E3. Release shows the same 3-edge latency.
- Busy equals (state != IDLE).

Test Plan:
- Decoded DMA write: Address=16'hFFF5, AEN=0, nIOW low 8 clocks → nCS=2'b10 after 3rd edge, WrStb high exactly 1 clock, DevIdx=0. nCS returns to 2'b11 3 edges after nIOW rises; Busy stays high 2 further clocks.
- Second window read: Address=16'h008F, nIOR low → nCS=2'b01, RdStb 1-cycle pulse, DevIdx=1. Address changed to 16'hFFF0 mid-access leaves nCS unchanged.
- Miss and AEN: Address=16'h1234 with nIOR low → DecodeMiss 1 pulse, nCS=2'b11. Address=16'hFFF0 with AEN=1 and nIOW low → no nCS, no pulses, Busy high until release.
- Conflict: nIOR and nIOW low on the same clock at Address=16'hFFF0 → Conflict 1 pulse, no nCS. nIOW asserted during an ongoing read → Conflict pulse, nCS held until nIOR releases.
- Recovery/back-to-back: nIOW released then reasserted 1 clock later → second nCS assertion no earlier than RECOVERY_CYCLES+1 clocks after deassertion. Repeat with RECOVERY_CYCLES=0 for the minimum gap.
- Reset mid-access: nRESET pulled low while nCS=2'b10 → nCS=2'b11 and all pulses 0 asynchronously. After release with nIOW still low, a fresh WrStb is issued after 3 edges.

Source files
------------

// File: rtl/io_port_decoder.sv
// Clocked host I/O chip-select decoder: synchronises nIOR/nIOW, matches the address
// against NUM_DEV base windows and drives registered active-low selects plus event pulses.
module io_port_decoder #(
    parameter int ADDR_W          = 16,
    parameter int NUM_DEV         = 2,
    parameter int WINDOW_BITS     = 4,
    parameter logic [NUM_DEV*ADDR_W-1:0] BASE_ADDRS = {16'h0080, 16'hFFF0},
    parameter int SYNC_STAGES     = 2,
    parameter int RECOVERY_CYCLES = 2,
    localparam int IDX_W          = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1
) (
    input  logic                CLK,
    input  logic                nRESET,
    input  logic [ADDR_W-1:0]   Address,
    input  logic                nIOR,
    input  logic                nIOW,
    input  logic                AEN,
    output logic [NUM_DEV-1:0]  nCS,
    output logic [IDX_W-1:0]    DevIdx,
    output logic                RdStb,
    output logic                WrStb,
    output logic                DecodeMiss,
    output logic                Conflict,
    output logic                Busy
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACCESS    = 2'd1,
        HOLD_MISS = 2'd2,
        RECOVER   = 2'd3
    } state_t;

    localparam logic [3:0] REC_LOAD = (RECOVERY_CYCLES > 0) ? 4'(RECOVERY_CYCLES - 1) : 4'd0;

    state_t                 state_r;
    logic [3:0]             recCnt_r;
    logic                   ownerWr_r;
    logic                   otherSeen_r;
    logic [SYNC_STAGES-1:0] rdSync_r;
    logic [SYNC_STAGES-1:0] wrSync_r;

    logic                   rd_s;
    logic                   wr_s;
    logic                   accOrig_s;
    logic                   accOther_s;
    logic                   hitAny_s;
    logic [IDX_W-1:0]       hitIdx_s;
    logic                   addrLowUnused_s;

    // The chains carry pin levels, so idle is all ones; the decision stage sees active-high strobes.
    assign rd_s       = ~rdSync_r[SYNC_STAGES-1];
    assign wr_s       = ~wrSync_r[SYNC_STAGES-1];
    assign accOrig_s  = ownerWr_r ? wr_s : rd_s;
    assign accOther_s = ownerWr_r ? rd_s : wr_s;
    assign addrLowUnused_s = ^Address;

    // Strobe synchroniser chains.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            rdSync_r <= '1;
            wrSync_r <= '1;
        end else begin
            rdSync_r[0] <= nIOR;
            wrSync_r[0] <= nIOW;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                rdSync_r[i] <= rdSync_r[i-1];
                wrSync_r[i] <= wrSync_r[i-1];
            end
        end
    end

    // Window match; scanning downwards lets the lowest matching index win.
    always_comb begin
        hitAny_s = 1'b0;
        hitIdx_s = '0;
        for (int k = NUM_DEV - 1; k >= 0; k--) begin
            if (Address[ADDR_W-1:WINDOW_BITS] ==
                BASE_ADDRS[k*ADDR_W+WINDOW_BITS +: ADDR_W-WINDOW_BITS]) begin
                hitAny_s = 1'b1;
                hitIdx_s = IDX_W'(k);
            end else begin
                hitAny_s = hitAny_s;
                hitIdx_s = hitIdx_s;
            end
        end
    end

    // Access sequencer with registered selects, pulses and busy flag.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_r     <= IDLE;
            recCnt_r    <= 4'd0;
            ownerWr_r   <= 1'b0;
            otherSeen_r <= 1'b0;
            nCS         <= '1;
            DevIdx      <= '0;
            RdStb       <= 1'b0;
            WrStb       <= 1'b0;
            DecodeMiss  <= 1'b0;
            Conflict    <= 1'b0;
            Busy        <= 1'b0;
        end else begin
            RdStb      <= 1'b0;
            WrStb      <= 1'b0;
            DecodeMiss <= 1'b0;
            Conflict   <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (rd_s && wr_s) begin
                        Conflict <= 1'b1;
                        state_r  <= HOLD_MISS;
                        Busy     <= 1'b1;
                    end else if (rd_s || wr_s) begin
                        Busy <= 1'b1;
                        if (AEN) begin
                            state_r <= HOLD_MISS;
                        end else if (hitAny_s) begin
                            state_r     <= ACCESS;
                            nCS         <= ~(NUM_DEV'(1'b1) << hitIdx_s);
                            DevIdx      <= hitIdx_s;
                            RdStb       <= rd_s;
                            WrStb       <= wr_s;
                            ownerWr_r   <= wr_s;
                            otherSeen_r <= 1'b0;
                        end else begin
                            DecodeMiss <= 1'b1;
                            state_r    <= HOLD_MISS;
                        end
                    end else begin
                        state_r <= IDLE;
                        Busy    <= 1'b0;
                    end
                end
                ACCESS: begin
                    // The device stays latched; only the originating strobe ends the access.
                    if (!accOrig_s) begin
                        nCS <= '1;
                        if (RECOVERY_CYCLES == 0) begin
                            state_r <= IDLE;
                            Busy    <= 1'b0;
                        end else begin
                            state_r  <= RECOVER;
                            recCnt_r <= REC_LOAD;
                        end
                    end else if (accOther_s && !otherSeen_r) begin
                        Conflict    <= 1'b1;
                        otherSeen_r <= 1'b1;
                    end else begin
                        otherSeen_r <= accOther_s;
                    end
                end
                HOLD_MISS: begin
                    if (!rd_s && !wr_s) begin
                        if (RECOVERY_CYCLES == 0) begin
                            state_r <= IDLE;
                            Busy    <= 1'b0;
                        end else begin
                            state_r  <= RECOVER;
                            recCnt_r <= REC_LOAD;
                        end
                    end else begin
                        state_r <= HOLD_MISS;
                    end
                end
                RECOVER: begin
                    if (recCnt_r == 4'd0) begin
                        state_r <= IDLE;
                        Busy    <= 1'b0;
                    end else begin
                        recCnt_r <= recCnt_r - 4'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    nCS     <= '1;
                    Busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
